// File: rtl/multicycle_stall_ctrl.sv
// multicycle_stall_ctrl: N-channel stall sequencer for multi-cycle EX/MEM units.
// Each channel holds the pipeline until its op latency expires, then pulses done.
module multicycle_stall_ctrl #(
   parameter int                        NUM_CH  = 2,
   parameter int                        CNT_W   = 6,
   // ch0 = dmem (1 cycle), ch1 = divider (33 cycles)
   parameter logic [NUM_CH*CNT_W-1:0]   LAT_VEC = {6'd33, 6'd1},
   parameter logic [NUM_CH-1:0]         DYN_LAT = {NUM_CH{1'b0}}
) (
   input  logic                       clk,
   input  logic                       resetn,
   input  logic [NUM_CH-1:0]          start_i,
   input  logic [NUM_CH*CNT_W-1:0]    lat_i,
   input  logic [NUM_CH-1:0]          flush_i,
   input  logic                       adv_i,
   output logic                       stall_o,
   output logic [NUM_CH-1:0]          ch_stall_o,
   output logic [NUM_CH-1:0]          unit_clr_o,
   output logic [NUM_CH-1:0]          busy_o,
   output logic [NUM_CH-1:0]          done_o,
   output logic [31:0]                stall_cnt_o
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_WAIT = 2'd2;

   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   logic [1:0]       state   [NUM_CH];
   logic [CNT_W-1:0] cnt     [NUM_CH];
   logic [CNT_W-1:0] lat_eff [NUM_CH];
   logic [NUM_CH-1:0] hold;
   logic [NUM_CH-1:0] accept;
   logic [NUM_CH-1:0] multi;
   logic [NUM_CH-1:0] finish;

   // Combinational outputs are qualified with resetn so everything reads 0 during reset.
   always_comb begin
      // NOTE: every output of this block gets a default before the loop so no latch is inferred.
      accept     = '0;
      multi      = '0;
      finish     = '0;
      ch_stall_o = '0;
      unit_clr_o = '0;
      done_o     = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         lat_eff[c] = DYN_LAT[c] ? lat_i[c*CNT_W +: CNT_W] : LAT_VEC[c*CNT_W +: CNT_W];
         multi[c]   = lat_eff[c] > ONE;
         accept[c]  = resetn && (state[c] == ST_IDLE) && start_i[c] && !flush_i[c]
                      && !hold[c] && (lat_eff[c] != '0);
         finish[c]  = resetn && (state[c] == ST_BUSY) && !flush_i[c] && (cnt[c] == ONE);
         unit_clr_o[c] = accept[c];
         done_o[c]     = (accept[c] && !multi[c]) || finish[c];
         ch_stall_o[c] = (accept[c] && multi[c])
                         || (resetn && (state[c] == ST_BUSY) && !flush_i[c] && (cnt[c] > ONE));
      end
   end

   assign stall_o = |ch_stall_o;

   always_comb begin
      busy_o = '0;
      for (int c = 0; c < NUM_CH; c++) busy_o[c] = (state[c] == ST_BUSY);
   end

   // hold blocks a still-asserted start_i from relaunching the op that just finished
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int c = 0; c < NUM_CH; c++) begin
            state[c] <= ST_IDLE;
            cnt[c]   <= '0;
         end
         hold <= '0;
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            // NOTE: state registers use non-blocking assignment so every channel sees pre-edge values.
            case (state[c])
               ST_IDLE: begin
                  if (!start_i[c] || flush_i[c]) hold[c] <= 1'b0;
                  if (accept[c] && multi[c]) begin
                     state[c] <= ST_BUSY;
                     cnt[c]   <= lat_eff[c] - ONE;
                  end else if (accept[c] && !adv_i) begin
                     state[c] <= ST_WAIT;
                  end
               end
               ST_BUSY: begin
                  if (flush_i[c]) begin
                     state[c] <= ST_IDLE;
                     hold[c]  <= 1'b0;
                  end else if (cnt[c] == ONE) begin
                     state[c] <= adv_i ? ST_IDLE : ST_WAIT;
                     hold[c]  <= 1'b1;
                  end else begin
                     cnt[c] <= cnt[c] - ONE;
                  end
               end
               ST_WAIT: begin
                  if (flush_i[c]) begin
                     state[c] <= ST_IDLE;
                     hold[c]  <= 1'b0;
                  end else if (adv_i) begin
                     state[c] <= ST_IDLE;
                     hold[c]  <= 1'b1;
                  end
               end
               default: state[c] <= ST_IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)                            stall_cnt_o <= '0;
      else if (stall_o && stall_cnt_o != '1)  stall_cnt_o <= stall_cnt_o + 32'd1;
   end

endmodule

// File: tb/tb_multicycle_stall_ctrl.sv
// Bench for multicycle_stall_ctrl: directed scenarios plus random traffic, checked every cycle
// against an op-age model (ch0 static latency 1, ch1 latency taken from lat_i).
module tb_multicycle_stall_ctrl;

   logic        clk = 1'b0;
   logic        resetn;
   logic [1:0]  start_i;
   logic [11:0] lat_i;
   logic [1:0]  flush_i;
   logic        adv_i;
   logic        stall_o;
   logic [1:0]  ch_stall_o, unit_clr_o, busy_o, done_o;
   logic [31:0] stall_cnt_o;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   multicycle_stall_ctrl #(
      .NUM_CH (2),
      .CNT_W  (6),
      .LAT_VEC({6'd33, 6'd1}),
      .DYN_LAT(2'b10)
   ) dut (
      .clk        (clk),
      .resetn     (resetn),
      .start_i    (start_i),
      .lat_i      (lat_i),
      .flush_i    (flush_i),
      .adv_i      (adv_i),
      .stall_o    (stall_o),
      .ch_stall_o (ch_stall_o),
      .unit_clr_o (unit_clr_o),
      .busy_o     (busy_o),
      .done_o     (done_o),
      .stall_cnt_o(stall_cnt_o)
   );

   task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
      n_vec++;
      if (actual !== expected) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
      end
   endtask

   // ---------------- behavioural model: each op described by start cycle and latency ----------------
   bit     op_active [2];   // launched multi-cycle op still running
   bit     op_waiting[2];   // op finished but held by an external stall
   bit     guard     [2];   // start_i has stayed high since the last op ended
   int     op_t0     [2];
   int     op_lat    [2];
   int     cyc = 0;
   longint m_cnt = 0;

   function automatic int lat_of(input int c);
      return (c == 0) ? 1 : int'(lat_i[11:6]);
   endfunction

   logic [1:0] e_stall, e_clr, e_busy, e_done;
   bit         acc_a[2];
   int         lat_a[2];

   always @(negedge clk) begin
      e_stall = '0; e_clr = '0; e_busy = '0; e_done = '0;
      if (resetn !== 1'b1) begin
         for (int c = 0; c < 2; c++) begin
            op_active[c] = 0; op_waiting[c] = 0; guard[c] = 0; acc_a[c] = 0;
         end
         m_cnt = 0;
      end else begin
         for (int c = 0; c < 2; c++) begin
            int age;
            lat_a[c] = lat_of(c);
            acc_a[c] = 0;
            if (op_active[c]) begin
               age = cyc - op_t0[c];
               e_busy[c] = 1'b1;
               if (!flush_i[c]) begin
                  e_stall[c] = (age < op_lat[c] - 1);
                  e_done[c]  = (age == op_lat[c] - 1);
               end
            end else if (!op_waiting[c]) begin
               acc_a[c]   = start_i[c] && !flush_i[c] && !guard[c] && (lat_a[c] > 0);
               e_clr[c]   = acc_a[c];
               e_stall[c] = acc_a[c] && (lat_a[c] >= 2);
               e_done[c]  = acc_a[c] && (lat_a[c] == 1);
            end
         end
      end
      if (resetn !== 1'bx) begin
         check("stall_o",     64'(stall_o),     64'(|e_stall));
         check("ch_stall_o",  64'(ch_stall_o),  64'(e_stall));
         check("unit_clr_o",  64'(unit_clr_o),  64'(e_clr));
         check("busy_o",      64'(busy_o),      64'(e_busy));
         check("done_o",      64'(done_o),      64'(e_done));
         check("stall_cnt_o", 64'(stall_cnt_o), 64'(m_cnt));
      end
      if (resetn === 1'b1) begin
         if (|e_stall && m_cnt != 64'hFFFF_FFFF) m_cnt++;
         for (int c = 0; c < 2; c++) begin
            if (op_active[c]) begin
               if (flush_i[c]) begin
                  op_active[c] = 0; guard[c] = 0;
               end else if (cyc - op_t0[c] == op_lat[c] - 1) begin
                  op_active[c] = 0;
                  if (adv_i) guard[c] = 1; else op_waiting[c] = 1;
               end
            end else if (op_waiting[c]) begin
               if (flush_i[c]) begin
                  op_waiting[c] = 0; guard[c] = 0;
               end else if (adv_i) begin
                  op_waiting[c] = 0; guard[c] = 1;
               end
            end else begin
               if (flush_i[c] || !start_i[c]) guard[c] = 0;
               if (acc_a[c] && lat_a[c] >= 2) begin
                  op_active[c] = 1; op_t0[c] = cyc; op_lat[c] = lat_a[c];
               end else if (acc_a[c] && !adv_i) begin
                  op_waiting[c] = 1;
               end
            end
         end
      end
      cyc++;
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   int          k;
   logic [31:0] base;

   initial begin
      resetn  = 1'b1;
      start_i = 2'b11;
      flush_i = 2'b00;
      adv_i   = 1'b1;
      lat_i   = {6'd33, 6'd0};
      #2 resetn = 1'b0;

      // reset with both starts asserted
      repeat (3) tick();
      #1;
      check("rst_outputs", 64'({stall_o, ch_stall_o, unit_clr_o, busy_o, done_o}), 64'd0);
      check("rst_cnt", 64'(stall_cnt_o), 64'd0);
      tick(); start_i = 2'b00; resetn = 1'b1;
      tick(); #1; check("rel_cnt", 64'(stall_cnt_o), 64'd0);

      // divider: start held high with adv_i=1
      tick(); start_i = 2'b10; #1;
      check("div_clr", 64'(unit_clr_o), 64'b10);
      check("div_stall0", 64'(stall_o), 64'd1);
      k = -1;
      for (int i = 1; i <= 40; i++) begin
         tick(); #1;
         if (done_o[1]) begin k = i; break; end
      end
      check("div_done_cycle", 64'(k), 64'd32);
      check("div_stall_at_done", 64'(stall_o), 64'd0);
      check("div_stall_cnt", 64'(stall_cnt_o), 64'd32);
      tick(); #1; check("div_no_relaunch", 64'(unit_clr_o[1]), 64'd0);
      tick(); start_i = 2'b00;
      tick(); start_i = 2'b10; #1; check("div_relaunch", 64'(unit_clr_o[1]), 64'd1);
      tick(); start_i = 2'b00;
      repeat (35) tick();

      // dmem back-to-back, then held by adv_i=0
      for (int i = 0; i < 5; i++) begin
         tick(); start_i = 2'b01; #1;
         check("dmem_done", 64'(done_o[0]), 64'd1);
         check("dmem_nostall", 64'(stall_o), 64'd0);
      end
      tick(); adv_i = 1'b0; #1; check("dmem_done_adv0", 64'(done_o[0]), 64'd1);
      repeat (3) begin
         tick(); #1; check("dmem_held", 64'({done_o[0], unit_clr_o[0]}), 64'd0);
      end
      tick(); adv_i = 1'b1; #1; check("dmem_wait_release", 64'(done_o[0]), 64'd0);
      tick(); #1; check("dmem_guard", 64'(unit_clr_o[0]), 64'd0);
      tick(); start_i = 2'b00;
      tick();

      // overlap: ch1 at cycle 0, ch0 at cycle 5, adv_i=0 until cycle 40
      tick(); adv_i = 1'b0; start_i = 2'b10; base = stall_cnt_o;
      for (int i = 1; i <= 40; i++) begin
         tick();
         if (i == 5)  start_i = 2'b11;
         if (i == 40) adv_i = 1'b1;
      end
      #1;
      check("ovl_busy_wait", 64'(busy_o), 64'd0);
      check("ovl_stall_cycles", 64'(stall_cnt_o - base), 64'd32);
      tick(); #1; check("ovl_idle_guard", 64'({unit_clr_o, done_o}), 64'd0);
      tick(); start_i = 2'b00;
      tick();

      // flush in cycle 10 of a divide, restart in cycle 11
      tick(); start_i = 2'b10;
      for (int i = 1; i <= 10; i++) begin
         tick();
         if (i == 10) flush_i = 2'b10;
      end
      #1;
      check("flush_stall", 64'(stall_o), 64'd0);
      check("flush_done", 64'(done_o), 64'd0);
      tick(); flush_i = 2'b00; #1;
      check("flush_restart_clr", 64'(unit_clr_o[1]), 64'd1);
      check("flush_idle", 64'(busy_o[1]), 64'd0);
      tick(); flush_i = 2'b10; start_i = 2'b00;
      tick(); flush_i = 2'b00;
      tick();

      // dynamic latency 5 on ch1
      tick(); lat_i[11:6] = 6'd5; start_i = 2'b10;
      k = -1;
      for (int i = 1; i <= 10; i++) begin
         tick(); start_i = 2'b00; #1;
         if (done_o[1]) begin k = i; break; end
      end
      check("dyn5_done_cycle", 64'(k), 64'd4);
      tick(); tick();
      // dynamic latency 0: combinational op
      tick(); lat_i[11:6] = 6'd0; start_i = 2'b10; #1;
      check("dyn0_quiet", 64'({unit_clr_o[1], ch_stall_o[1], done_o[1]}), 64'd0);
      tick(); start_i = 2'b00;
      // async reset in cycle 2 of an op
      tick(); lat_i[11:6] = 6'd5; start_i = 2'b10;
      tick(); start_i = 2'b00;
      tick(); #1; check("pre_rst_busy", 64'(busy_o[1]), 64'd1);
      resetn = 1'b0; #1;
      check("async_rst_busy", 64'(busy_o), 64'd0);
      check("async_rst_stall", 64'(stall_o), 64'd0);
      tick(); tick(); resetn = 1'b1;
      tick();

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         tick();
         start_i     = 2'($urandom);
         flush_i     = ($urandom_range(0, 15) == 0) ? 2'($urandom) : 2'b00;
         adv_i       = ($urandom_range(0, 3) != 0);
         lat_i[11:6] = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(0, 63))
                                                    : 6'($urandom_range(0, 6));
         lat_i[5:0]  = 6'($urandom);
         resetn      = ($urandom_range(0, 499) != 0);
      end
      tick(); resetn = 1'b1;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
